// File: rtl/lbs_pkg.sv
// Shared definitions for the line-buffer sequencer: state encoding, pointer-clear
// polarity and the bundle of FIFO control strobes.
package lbs_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // The FIFO bank and its bench use the same polarity for both pointer clears.
  localparam logic PTCLR_ACTIVE = 1'b0;

  typedef struct packed {
    logic       rdptclr;
    logic       wrptclr;
    logic       rdinc;
    logic       wrinc;
    logic [1:0] ren;
    logic [1:0] wen;
  } fifo_ctrl_t;

  localparam fifo_ctrl_t FIFO_CTRL_IDLE = '{
    rdptclr: ~PTCLR_ACTIVE,
    wrptclr: ~PTCLR_ACTIVE,
    rdinc:   1'b0,
    wrinc:   1'b0,
    ren:     2'b00,
    wen:     2'b00
  };

endpackage

// File: rtl/wrap_counter.sv
// Up-counter with synchronous clear that wraps to zero after reaching a run-time
// terminal value; wrap flags the terminal count so the parent can chain counters.
module wrap_counter #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] terminal,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  assign count = count_q;
  assign wrap  = (count_q == terminal);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = wrap ? '0 : count_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge inputs regardless of the order the always blocks execute in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/line_buffer_sequencer.sv
// Sequencer for the two line FIFOs feeding the 3x3 convolution window: tracks
// raster position, decodes FIFO strobes, and flags complete windows.
module line_buffer_sequencer
  import lbs_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_WIDTH  = 720
) (
  input  logic                  LBS_Clk,
  input  logic                  LBS_Reset_InLow,
  input  logic                  LBS_Start,
  input  logic [ADDR_WIDTH-1:0] LBS_Width,
  input  logic [ADDR_WIDTH-1:0] LBS_Height,
  input  logic                  LBS_Pix_Valid,
  output logic                  LBS_Pix_Ready,
  input  logic                  LBS_Win_Ready,
  output logic                  LBS_Fifo_Rdptclr,
  output logic                  LBS_Fifo_Wrptclr,
  output logic                  LBS_Fifo_Rdinc,
  output logic                  LBS_Fifo_Wrinc,
  output logic [1:0]            LBS_Fifo_Ren,
  output logic [1:0]            LBS_Fifo_Wen,
  output logic                  LBS_Sel,
  output logic [ADDR_WIDTH-1:0] LBS_Col,
  output logic [ADDR_WIDTH-1:0] LBS_Row,
  output logic                  LBS_Win_Valid,
  output logic                  LBS_Busy,
  output logic                  LBS_Done,
  output logic                  LBS_Cfg_Err
);

  if (DATA_WIDTH < 1 || MAX_WIDTH >= (1 << ADDR_WIDTH)) begin : g_param_check
    $error("line_buffer_sequencer: DATA_WIDTH must be >= 1 and MAX_WIDTH must fit ADDR_WIDTH");
  end

  localparam logic [ADDR_WIDTH-1:0] MAX_W   = ADDR_WIDTH'(MAX_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] MIN_DIM = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] WIN_MIN = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] ONE     = ADDR_WIDTH'(1);

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] width_q, width_d;
  logic [ADDR_WIDTH-1:0] height_q, height_d;
  logic [ADDR_WIDTH-1:0] row_out_q, row_out_d;
  logic [ADDR_WIDTH-1:0] col_out_q, col_out_d;
  logic                  win_valid_q, win_valid_d;
  logic                  sel_q, sel_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  cfg_err_q, cfg_err_d;

  logic [ADDR_WIDTH-1:0] col_cnt, row_cnt;
  logic                  col_wrap, row_wrap;
  logic                  cnt_clear, accept, cfg_ok, at_window;
  fifo_ctrl_t            fifo_ctrl;

  assign cnt_clear = (state_q == ST_CLEAR);
  assign accept    = (state_q == ST_RUN) && LBS_Win_Ready && LBS_Pix_Valid;
  assign cfg_ok    = (LBS_Width >= MIN_DIM) && (LBS_Width <= MAX_W) && (LBS_Height >= MIN_DIM);
  assign at_window = (row_cnt >= WIN_MIN) && (col_cnt >= WIN_MIN);

  wrap_counter #(.WIDTH(ADDR_WIDTH)) u_col_cnt (
    .clk      (LBS_Clk),
    .rst_n    (LBS_Reset_InLow),
    .clear    (cnt_clear),
    .enable   (accept),
    .terminal (width_q - ONE),
    .count    (col_cnt),
    .wrap     (col_wrap)
  );

  wrap_counter #(.WIDTH(ADDR_WIDTH)) u_row_cnt (
    .clk      (LBS_Clk),
    .rst_n    (LBS_Reset_InLow),
    .clear    (cnt_clear),
    .enable   (accept && col_wrap),
    .terminal (height_q - ONE),
    .count    (row_cnt),
    .wrap     (row_wrap)
  );

  // NOTE: every variable driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    width_d   = width_q;
    height_d  = height_q;
    done_d    = 1'b0;
    cfg_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (LBS_Start) begin
          if (cfg_ok) begin
            width_d  = LBS_Width;
            height_d = LBS_Height;
            state_d  = ST_CLEAR;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_CLEAR: state_d = ST_RUN;
      ST_RUN: begin
        if (accept && col_wrap && row_wrap) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Row/Col report the pixel just taken, whereas the counters point at the next one.
  always_comb begin
    win_valid_d = accept && at_window;
    sel_d       = (accept && at_window) ? row_cnt[0] : sel_q;
    row_out_d   = row_out_q;
    col_out_d   = col_out_q;
    if (cnt_clear) begin
      row_out_d = '0;
      col_out_d = '0;
    end else if (accept) begin
      row_out_d = row_cnt;
      col_out_d = col_cnt;
    end
  end

  // Row r overwrites row r-2 in FIFO (r mod 2); a line-end accept clears the
  // pointers instead of incrementing them so both FIFOs wrap to address 0.
  always_comb begin
    fifo_ctrl = FIFO_CTRL_IDLE;
    if (state_q == ST_CLEAR) begin
      fifo_ctrl.rdptclr = PTCLR_ACTIVE;
      fifo_ctrl.wrptclr = PTCLR_ACTIVE;
    end else if (accept) begin
      fifo_ctrl.ren = 2'b11;
      fifo_ctrl.wen = row_cnt[0] ? 2'b10 : 2'b01;
      if (col_wrap) begin
        fifo_ctrl.rdptclr = PTCLR_ACTIVE;
        fifo_ctrl.wrptclr = PTCLR_ACTIVE;
      end else begin
        fifo_ctrl.rdinc = 1'b1;
        fifo_ctrl.wrinc = 1'b1;
      end
    end
  end

  always_ff @(posedge LBS_Clk or negedge LBS_Reset_InLow) begin
    if (!LBS_Reset_InLow) begin
      state_q     <= ST_IDLE;
      width_q     <= '0;
      height_q    <= '0;
      row_out_q   <= '0;
      col_out_q   <= '0;
      win_valid_q <= 1'b0;
      sel_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      width_q     <= width_d;
      height_q    <= height_d;
      row_out_q   <= row_out_d;
      col_out_q   <= col_out_d;
      win_valid_q <= win_valid_d;
      sel_q       <= sel_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign LBS_Pix_Ready    = (state_q == ST_RUN) && LBS_Win_Ready;
  assign LBS_Fifo_Rdptclr = fifo_ctrl.rdptclr;
  assign LBS_Fifo_Wrptclr = fifo_ctrl.wrptclr;
  assign LBS_Fifo_Rdinc   = fifo_ctrl.rdinc;
  assign LBS_Fifo_Wrinc   = fifo_ctrl.wrinc;
  assign LBS_Fifo_Ren     = fifo_ctrl.ren;
  assign LBS_Fifo_Wen     = fifo_ctrl.wen;
  assign LBS_Sel          = sel_q;
  assign LBS_Row          = row_out_q;
  assign LBS_Col          = col_out_q;
  assign LBS_Win_Valid    = win_valid_q;
  assign LBS_Busy         = busy_q;
  assign LBS_Done         = done_q;
  assign LBS_Cfg_Err      = cfg_err_q;

endmodule

// File: doc/line_buffer_sequencer.md
# line_buffer_sequencer

Controller for the two on-chip line FIFOs that form the row buffers of the 3x3 convolution window. It accepts a raster pixel stream and drives the FIFO pointer-clear, pointer-increment, write-enable and read-enable strobes. It tracks row and column and tells the window datapath when a full 3x3 window is available and which FIFO holds which row. It sits between the input pixel stream and the FIFO bank, upstream of the MAC array.

## Interface
- DATA_WIDTH, 16, pixel width; passed through to the FIFO bank, not used internally.
- ADDR_WIDTH, 10, width of the FIFO address, column counter and row counter.
- MAX_WIDTH, 720, largest legal image width; equals the FIFO depth.

Ports:
- LBS_Clk  in  1  clock; all state changes on the rising edge.
- LBS_Reset_InLow  in  1  asynchronous, active-low reset.
- LBS_Start  in  1  single-cycle pulse; latches Width/Height and starts a frame.
- LBS_Width  in  ADDR_WIDTH  image width W; legal range 3..MAX_WIDTH.
- LBS_Height  in  ADDR_WIDTH  image height H; must be at least 3.
- LBS_Pix_Valid  in  1  input pixel present.
- LBS_Pix_Ready  out  1  controller accepts a pixel this cycle.
- LBS_Win_Ready  in  1  downstream window consumer can take a window.
- LBS_Fifo_Rdptclr  out  1  active-low read-pointer clear, shared by both FIFOs.
- LBS_Fifo_Wrptclr  out  1  active-low write-pointer clear, shared by both FIFOs.
- LBS_Fifo_Rdinc  out  1  read-pointer increment.
- LBS_Fifo_Wrinc  out  1  write-pointer increment.
- LBS_Fifo_Ren  out  2  per-FIFO read enable.
- LBS_Fifo_Wen  out  2  per-FIFO write enable.
- LBS_Sel  out  1  row parity of the window just completed; tells the datapath which FIFO holds row r-2.
- LBS_Col, LBS_Row  out  ADDR_WIDTH  position of the last accepted pixel.
- LBS_Win_Valid  out  1  a complete window is available at the FIFO outputs.
- LBS_Busy  out  1  a frame is in progress.
- LBS_Done  out  1  one-cycle pulse at the end of a frame.
- LBS_Cfg_Err  out  1  one-cycle pulse when Start is rejected.

## Operation
- States: IDLE, CLEAR, RUN, DONE.
- IDLE:
  - Start with W in 3..MAX_WIDTH and H ≥ 3 latches the config and moves to CLEAR.
  - Any other Start pulses Cfg_Err and stays in IDLE.
- Start is ignored in every state other than IDLE.
- CLEAR (exactly 1 cycle):
  - Rdptclr = Wrptclr = 0.
  - Row and Col counters are zeroed.
  - Next state is RUN.
- RUN:
  - Pix_Ready = Win_Ready; a pixel is accepted when Pix_Valid & Pix_Ready.
  - On each accept, Ren = 2'b11 and Wen[r mod 2] = 1, so row r overwrites row r-2 in FIFO (r mod 2).
  - The FIFO bank must return the pre-write contents on a same-address read/write.
  - Accept at col < W-1: Rdinc = Wrinc = 1 and the clears stay at 1.
  - Accept at col = W-1: Rdinc = Wrinc = 0 and Rdptclr = Wrptclr = 0, so the pointers wrap to 0. Col wraps to 0 and Row increments.
  - No accept: all strobes are inactive (inc = 0, en = 0, clr = 1).
- Windows: an accept at row ≥ 2 and col ≥ 2 sets Win_Valid on the next cycle, with Sel = r mod 2.
- End of frame: an accept at (W-1, H-1) moves to DONE. DONE pulses Done for 1 cycle and returns to IDLE.
- Busy = 1 in CLEAR, RUN and DONE.

## Timing
- FIFO strobes and Pix_Ready are combinational decodes of registered state, registered counters, Pix_Valid and Win_Ready. This puts them in the same cycle as the pixel on the FIFO data input.
- Win_Valid, Sel, Row, Col, Busy, Done and Cfg_Err are registered.
- Win_Valid latency is 1 cycle after the accept, matching the FIFO's 1-cycle read latency.
- Reset values:
  - Rdptclr = Wrptclr = 1.
  - Rdinc = Wrinc = 0, Ren = Wen = 0.
  - Pix_Ready = 0, Win_Valid = 0, Sel = 0.
  - Row = Col = 0.
  - Busy = Done = Cfg_Err = 0.
  - State is IDLE.
- Reset asserted mid-frame: immediate return to IDLE with the values above. FIFO contents are stale but harmless, because the next CLEAR resets the pointers.
- Win_Ready low in RUN: no accepts and no strobes. Counters hold; Win_Valid deasserts on the next cycle.
- Start in the same cycle as the final accept is ignored.

## Structure
- Shared package lbs_pkg holds:
  - State encoding localparams (IDLE=0, CLEAR=1, RUN=2, DONE=3).
  - The PTCLR_ACTIVE = 1'b0 constant, shared with the FIFO bank and its bench.
- One sub-module, wrap_counter (enable, clear, terminal value, wrap flag), instantiated twice: once for Col, once for Row.

## Test plan
- W = 4, H = 3, Win_Ready held 1, pixels 1..12 streamed back-to-back:
  - Exactly 2 Win_Valid pulses, after the accepts of pixels 11 and 12, each with Sel = 0.
  - Pointer clears pulse at cols 3 of rows 0, 1 and 2.
  - Done is seen 1 cycle after pixel 12 is accepted.
- Start with W = 2, and separately with H = 0: Cfg_Err pulses once, Busy stays 0, no strobes.
- W = 5, H = 4, Win_Ready toggled every other cycle: no strobe while Win_Ready = 0; Win_Valid count is 6; final Row = 3, Col = 4.
- Reset asserted at row 2, col 1 of a W = 4 frame: all outputs take reset values immediately. A following W = 3, H = 3 frame yields exactly 1 Win_Valid.
- Start pulsed during RUN: ignored; the counters and Wen pattern are unchanged.
- W = MAX_WIDTH, H = 3: the pointers clear at col 719 and Col never exceeds 719.
